// File: rtl/alu_arbiter_if.sv
// Handshake and data bundle for alu_arbiter.
// slave: the arbiter side. master: the side that drives requests and consumes responses.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();

    // Requester 0
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [DATA_W-1:0] i_req0_a;
    logic [DATA_W-1:0] i_req0_b;
    logic [1:0]        i_req0_op;

    // Requester 1
    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [DATA_W-1:0] i_req1_a;
    logic [DATA_W-1:0] i_req1_b;
    logic [1:0]        i_req1_op;

    // Response channel and status
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic              o_rsp_id;
    logic [DATA_W-1:0] o_rsp_result;
    logic              o_busy;

    modport slave (
        input  i_req0_valid, i_req0_a, i_req0_b, i_req0_op,
        input  i_req1_valid, i_req1_a, i_req1_b, i_req1_op,
        input  i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_rsp_valid, o_rsp_id, o_rsp_result, o_busy
    );

    modport master (
        output i_req0_valid, i_req0_a, i_req0_b, i_req0_op,
        output i_req1_valid, i_req1_a, i_req1_b, i_req1_op,
        output i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp_valid, o_rsp_id, o_rsp_result, o_busy
    );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one bitwise logic unit through an IDLE/EXEC/RESP FSM.
// Default arbitration is round-robin with a last-served pointer (reset to 1, so requester 0
// wins the first tie). Define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0
// always wins ties, no pointer).
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [1:0] OpAnd  = 2'b00;
    localparam logic [1:0] OpOr   = 2'b01;
    localparam logic [1:0] OpXor  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    // Pure bitwise evaluation; no carries, no width extension.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        unique case (op)
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpXor:   r = a ^ b;
            OpPass:  r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic any_valid;
    logic grant_id;
    logic in_idle;

    assign any_valid = bus.i_req0_valid | bus.i_req1_valid;
    // Reset gates the grant so ready stays low while reset is held.
    assign in_idle   = (state_q == StIdle) & i_rst_n;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_id = ~bus.i_req0_valid;
    end
`else
    logic last_q, last_d;

    // Round-robin pick: on a tie grant the requester not served last, else the lone valid one.
    always_comb begin
        if (bus.i_req0_valid && bus.i_req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = ~bus.i_req0_valid;
        end
    end

    // Last-served pointer next state: follows every grant taken in IDLE.
    always_comb begin
        last_d = last_q;
        if (in_idle && any_valid) begin
            last_d = grant_id;
        end
    end

    // Last-served pointer register; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // FSM next state, operand capture and result computation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d = StExec;
                    id_d    = grant_id;
                    if (grant_id) begin
                        a_d  = bus.i_req1_a;
                        b_d  = bus.i_req1_b;
                        op_d = bus.i_req1_op;
                    end else begin
                        a_d  = bus.i_req0_a;
                        b_d  = bus.i_req0_b;
                        op_d = bus.i_req0_op;
                    end
                end
            end
            StExec: begin
                result_d = alu_eval(op_q, a_q, b_q);
                state_d  = StResp;
            end
            StResp: begin
                if (bus.i_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    // Outputs: ready only to the granted, still-valid requester while idle.
    always_comb begin
        bus.o_req0_ready = in_idle & bus.i_req0_valid & ~grant_id;
        bus.o_req1_ready = in_idle & bus.i_req1_valid & grant_id;
        bus.o_rsp_valid  = (state_q == StResp);
        bus.o_rsp_id     = id_q;
        bus.o_rsp_result = result_q;
        bus.o_busy       = (state_q != StIdle);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width in bits.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_req0_valid / i_req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 o_req0_ready / o_req1_ready  output  1 each  requester 0/1 operation accepted this cycle.
REQ-006 i_req0_a, i_req0_b, i_req1_a, i_req1_b  input  DATA_W each  operands A/B per requester.
REQ-007 i_req0_op / i_req1_op  input  2 each  op code: 00 AND, 01 OR, 10 XOR, 11 pass A.
REQ-008 o_rsp_valid  output  1  result available.
REQ-009 i_rsp_ready  input  1  consumer accepts result.
REQ-010 o_rsp_id  output  1  requester index owning the result.
REQ-011 o_rsp_result  output  DATA_W  computed bitwise result.
REQ-012 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL share one bitwise logic unit between two requesters through a three-state FSM: IDLE, EXEC, RESP.
REQ-014 IDLE: if any i_reqN_valid is high, the block SHALL grant one requester, assert only that o_reqN_ready combinationally in the same cycle, capture its A, B, op and id, then move to EXEC; otherwise it SHALL stay in IDLE.
REQ-015 o_reqN_ready SHALL be high only in IDLE, only for the granted requester, and only while that requester's valid is high.
REQ-016 EXEC: the block SHALL compute the result from the captured op and operands, register it into o_rsp_result, and move to RESP unconditionally after exactly one cycle.
REQ-017 RESP: o_rsp_valid SHALL be high, and o_rsp_result and o_rsp_id SHALL hold stable until i_rsp_ready is sampled high; the block SHALL then return to IDLE.
REQ-018 Latency: a request accepted at edge N SHALL give o_rsp_valid high after edge N+2; peak throughput is one operation per 3 cycles.
REQ-019 Arbitration (default): round-robin; when both valids are high, grant the requester not served last; when only one is valid, grant it regardless of history.
REQ-020 The last-served pointer SHALL update on every grant in IDLE.
REQ-021 Requests arriving in EXEC or RESP SHALL NOT be acknowledged; requesters hold valid and operands until ready.
REQ-022 Operand or op changes on a requester after its handshake SHALL NOT affect the in-flight result.
REQ-023 An i_rsp_ready held high continuously SHALL still yield exactly one response per accepted request.
REQ-024 All result bits SHALL be computed bitwise over the full DATA_W width, with no carries or width extension.

Reset
REQ-025 When i_rst_n is low, the block SHALL asynchronously force: state IDLE, o_rsp_valid 0, o_rsp_result 0, o_rsp_id 0, o_busy 0, both o_reqN_ready 0, last-served pointer = 1 (requester 0 wins the first tie).
REQ-026 Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight operation without emitting a response.
REQ-027 After reset deassertion, the first grant SHALL be possible in the first clock cycle.

Configuration
REQ-028 Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority, with requester 0 always winning ties and the last-served pointer removed.
REQ-029 Without ALU_ARBITER_FIXED_PRIO_EN, the round-robin behaviour of REQ-019 and REQ-020 SHALL apply.
REQ-030 All other behaviour SHALL be identical in both builds.

Verification
REQ-031 Single op: req0 A=0xF0F0_F0F0, B=0xFF00_FF00, op=00, i_rsp_ready=1 -> ready0 pulses 1 cycle; 2 cycles later o_rsp_valid=1, result=0xF000_F000, id=0; then IDLE.
REQ-032 Op coverage: A=0x1234_5678, B=0x0F0F_0F0F, ops 01/10/11 -> results 0x1F3F_5F7F, 0x1D3B_5977, 0x1234_5678 in order.
REQ-033 Contention, round-robin build: both valid continuously for 4 ops -> grants and o_rsp_id sequence 0,1,0,1.
REQ-034 Contention, ALU_ARBITER_FIXED_PRIO_EN build: both valid, req0 never drops -> every response id=0 and ready1 never asserted.
REQ-035 Backpressure: i_rsp_ready=0 for 5 cycles in RESP with req1 valid -> result/id stable, ready1 stays 0, o_busy=1; after i_rsp_ready=1 -> IDLE, next cycle ready1=1.
REQ-036 Reset in RESP with a pending result -> o_rsp_valid=0 immediately (asynchronously), no response after release; next tie grants req0.
